// File: rtl/connect4_pkg.sv
// Shared constants and types for the Connect-4 win detector.
package connect4_pkg;

    localparam int ROWS  = 6;
    localparam int COLS  = 7;
    localparam int CELLS = ROWS * COLS;

    // Window index space: four direction groups laid end to end.
    localparam logic [6:0] NUM_WINDOWS = 7'd69;
    localparam logic [6:0] LAST_WINDOW = 7'd68;
    localparam logic [6:0] WIN_BASE_H  = 7'd0;
    localparam logic [6:0] WIN_BASE_V  = 7'd24;
    localparam logic [6:0] WIN_BASE_DR = 7'd45;
    localparam logic [6:0] WIN_BASE_DL = 7'd57;

    localparam logic [1:0] WINNER_NONE = 2'b00;
    localparam logic [1:0] WINNER_P1   = 2'b01;
    localparam logic [1:0] WINNER_P2   = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/win_window_lookup.sv
// Combinational map from a window index to its four cell indices and cell mask.
module win_window_lookup
    import connect4_pkg::*;
(
    input  logic [6:0]       i_idx,
    output logic [5:0]       o_cell0,
    output logic [5:0]       o_cell1,
    output logic [5:0]       o_cell2,
    output logic [5:0]       o_cell3,
    output logic [CELLS-1:0] o_mask
);

    logic [6:0] w_off;
    logic [2:0] w_row;
    logic [2:0] w_col;
    logic [5:0] w_step;
    logic [5:0] w_base;
    logic       w_valid;

    // Split the index into direction group, anchor (row, col) and cell stride.
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        w_off   = '0;
        w_row   = '0;
        w_col   = '0;
        w_step  = '0;
        w_valid = (i_idx < NUM_WINDOWS);
        if (i_idx < WIN_BASE_V) begin
            w_off  = i_idx - WIN_BASE_H;
            w_row  = 3'(w_off >> 2);
            w_col  = 3'(w_off & 7'd3);
            w_step = 6'd1;
        end else if (i_idx < WIN_BASE_DR) begin
            w_off  = i_idx - WIN_BASE_V;
            w_row  = 3'(w_off / 7'd7);
            w_col  = 3'(w_off % 7'd7);
            w_step = 6'd7;
        end else if (i_idx < WIN_BASE_DL) begin
            w_off  = i_idx - WIN_BASE_DR;
            w_row  = 3'(w_off >> 2);
            w_col  = 3'(w_off & 7'd3);
            w_step = 6'd8;
        end else if (w_valid) begin
            // Up-left windows start at column c+3 and step one row up, one column left.
            w_off  = i_idx - WIN_BASE_DL;
            w_row  = 3'(w_off >> 2);
            w_col  = 3'(w_off & 7'd3) + 3'd3;
            w_step = 6'd6;
        end
    end

    assign w_base  = ({3'b000, w_row} * 6'(COLS)) + {3'b000, w_col};
    assign o_cell0 = w_base;
    assign o_cell1 = w_base + w_step;
    assign o_cell2 = o_cell1 + w_step;
    assign o_cell3 = o_cell2 + w_step;

    // Light up the four cells of a valid window.
    always_comb begin
        o_mask = '0;
        if (w_valid) begin
            o_mask[o_cell0] = 1'b1;
            o_mask[o_cell1] = 1'b1;
            o_mask[o_cell2] = 1'b1;
            o_mask[o_cell3] = 1'b1;
        end
    end

endmodule

// File: rtl/win_detector.sv
// Scans all 69 four-in-a-row windows of a snapshot of the board, one per clock,
// and reports winner, draw and the winning cell mask.
module win_detector
    import connect4_pkg::*;
#(
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CELLS-1:0] in_gameboard,
    input  logic [CELLS-1:0] in_players_cells,
    output logic             busy,
    output logic             done,
    output logic [1:0]       winner,
    output logic             draw,
    output logic [CELLS-1:0] win_mask
);

    state_t           r_state;
    state_t           w_next_state;
    logic             w_accept;
    logic             w_record;
    logic             w_finish;

    logic [6:0]       r_idx;
    logic [CELLS-1:0] r_snap_board;
    logic [CELLS-1:0] r_snap_owner;

    // One-cycle evaluation stage: the result of window idx is acted on a cycle later.
    logic             r_eval_valid;
    logic             r_eval_hit;
    logic             r_eval_owner;
    logic             r_eval_last;
    logic [CELLS-1:0] r_eval_mask;

    logic             r_found;
    logic [1:0]       r_winner;
    logic             r_draw;
    logic [CELLS-1:0] r_win_mask;

    logic [5:0]       w_cell0;
    logic [5:0]       w_cell1;
    logic [5:0]       w_cell2;
    logic [5:0]       w_cell3;
    logic [CELLS-1:0] w_mask;
    logic             w_occupied;
    logic             w_same_owner;
    logic             w_hit;

    win_window_lookup u_lookup (
        .i_idx   (r_idx),
        .o_cell0 (w_cell0),
        .o_cell1 (w_cell1),
        .o_cell2 (w_cell2),
        .o_cell3 (w_cell3),
        .o_mask  (w_mask)
    );

    assign w_occupied   = r_snap_board[w_cell0] & r_snap_board[w_cell1]
                        & r_snap_board[w_cell2] & r_snap_board[w_cell3];
    assign w_same_owner = (r_snap_owner[w_cell0] == r_snap_owner[w_cell1])
                        && (r_snap_owner[w_cell0] == r_snap_owner[w_cell2])
                        && (r_snap_owner[w_cell0] == r_snap_owner[w_cell3]);
    assign w_hit        = w_occupied && w_same_owner;

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and control strobes.
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_record     = 1'b0;
        w_finish     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_next_state = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (r_eval_valid) begin
                    w_record = r_eval_hit && !r_found;
                    if ((EARLY_EXIT && r_eval_hit) || r_eval_last) begin
                        w_finish     = 1'b1;
                        w_next_state = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Window counter, result registers and first-win bookkeeping.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_idx        <= '0;
            r_eval_valid <= 1'b0;
            r_found      <= 1'b0;
            r_winner     <= WINNER_NONE;
            r_draw       <= 1'b0;
            r_win_mask   <= '0;
        end else if (w_accept) begin
            r_idx        <= '0;
            r_eval_valid <= 1'b0;
            r_found      <= 1'b0;
            r_winner     <= WINNER_NONE;
            r_draw       <= 1'b0;
            r_win_mask   <= '0;
        end else if (r_state == ST_SCAN) begin
            r_eval_valid <= 1'b1;
            if (r_idx != LAST_WINDOW) begin
                r_idx <= r_idx + 7'd1;
            end
            if (w_record) begin
                r_found    <= 1'b1;
                r_winner   <= r_eval_owner ? WINNER_P2 : WINNER_P1;
                r_win_mask <= r_eval_mask;
            end
            if (w_finish) begin
                r_draw <= (&r_snap_board) && !r_found && !r_eval_hit;
            end
        end
    end

    // Board snapshot and evaluation stage data.
    // NOTE: these are pure data registers qualified by r_eval_valid / r_state, so they carry no reset.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_snap_board <= in_gameboard;
            r_snap_owner <= in_players_cells;
        end
        if (r_state == ST_SCAN) begin
            r_eval_hit   <= w_hit;
            r_eval_owner <= r_snap_owner[w_cell0];
            r_eval_mask  <= w_mask;
            r_eval_last  <= (r_idx == LAST_WINDOW);
        end
    end

    assign busy     = (r_state == ST_SCAN);
    assign done     = (r_state == ST_DONE);
    assign winner   = r_winner;
    assign draw     = r_draw;
    assign win_mask = r_win_mask;

endmodule

// File: tb/tb_win_detector.sv
// Bench for win_detector: directed table, hand-written robustness sequences and
// random boards against a window-enumeration reference model. Runs an
// early-exit and a full-scan instance side by side on the same inputs.
module tb_win_detector;
    import connect4_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [41:0] in_gameboard;
    logic [41:0] in_players_cells;

    logic        busy_e, done_e, draw_e;
    logic [1:0]  winner_e;
    logic [41:0] mask_e;
    logic        busy_f, done_f, draw_f;
    logic [1:0]  winner_f;
    logic [41:0] mask_f;

    always #5 clk = ~clk;

    win_detector #(.EARLY_EXIT(1'b1)) dut_early (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .in_gameboard     (in_gameboard),
        .in_players_cells (in_players_cells),
        .busy             (busy_e),
        .done             (done_e),
        .winner           (winner_e),
        .draw             (draw_e),
        .win_mask         (mask_e)
    );

    win_detector #(.EARLY_EXIT(1'b0)) dut_full (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .in_gameboard     (in_gameboard),
        .in_players_cells (in_players_cells),
        .busy             (busy_f),
        .done             (done_f),
        .winner           (winner_f),
        .draw             (draw_f),
        .win_mask         (mask_f)
    );

    typedef struct {
        string       name;
        logic [41:0] board;
        logic [41:0] owner;
        logic [1:0]  winner;
        logic        draw;
        logic [41:0] mask;
        int          lat;
    } vec_t;

    vec_t vq[$];
    int   win_tab[69][4];
    int   n_vec  = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [41:0] bits4(input int a, input int b, input int c, input int d);
        logic [41:0] m;
        m    = '0;
        m[a] = 1'b1;
        m[b] = 1'b1;
        m[c] = 1'b1;
        m[d] = 1'b1;
        return m;
    endfunction

    // Enumerate the windows in scan order straight from the board geometry.
    task automatic build_windows();
        int k;
        k = 0;
        for (int r = 0; r < 6; r++)
            for (int c = 0; c < 4; c++) begin
                for (int i = 0; i < 4; i++) win_tab[k][i] = r * 7 + c + i;
                k++;
            end
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 7; c++) begin
                for (int i = 0; i < 4; i++) win_tab[k][i] = (r + i) * 7 + c;
                k++;
            end
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 4; c++) begin
                for (int i = 0; i < 4; i++) win_tab[k][i] = (r + i) * 7 + c + i;
                k++;
            end
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 4; c++) begin
                for (int i = 0; i < 4; i++) win_tab[k][i] = (r + i) * 7 + c + 3 - i;
                k++;
            end
    endtask

    task automatic model(input logic [41:0] b, input logic [41:0] o,
                         output logic [1:0] w, output logic d, output logic [41:0] m,
                         output int lat);
        int first;
        first = -1;
        for (int k = 0; k < 69; k++) begin
            if (first < 0) begin
                int occ, ones;
                occ  = 0;
                ones = 0;
                for (int i = 0; i < 4; i++) begin
                    occ  += int'(b[win_tab[k][i]]);
                    ones += int'(o[win_tab[k][i]]);
                end
                if (occ == 4 && (ones == 0 || ones == 4)) first = k;
            end
        end
        if (first < 0) begin
            w   = 2'b00;
            m   = '0;
            d   = &b;
            lat = 70;
        end else begin
            w   = o[win_tab[first][0]] ? 2'b10 : 2'b01;
            m   = bits4(win_tab[first][0], win_tab[first][1], win_tab[first][2], win_tab[first][3]);
            d   = 1'b0;
            lat = first + 2;
        end
    endtask

    task automatic add_vec(input string name, input logic [41:0] b, input logic [41:0] o,
                           input logic [1:0] w, input logic d, input logic [41:0] m, input int lat);
        vec_t v;
        v.name = name; v.board = b; v.owner = o; v.winner = w;
        v.draw = d;    v.mask = m;  v.lat = lat;
        vq.push_back(v);
    endtask

    // Start a scan at the next edge T, then watch both instances for 80 cycles.
    // Sample n is taken in the cycle after edge T+n.
    task automatic run_case(input string name, input logic [41:0] b, input logic [41:0] o,
                            input logic [1:0] ew, input logic ed, input logic [41:0] em,
                            input int elat);
        int          lat_e = -1, lat_f = -1, pul_e = 0, pul_f = 0;
        logic [1:0]  w_e = 2'b11, w_f = 2'b11;
        logic        d_e = 1'bx, d_f = 1'bx, bz_e = 1'bx;
        logic [41:0] m_e = '1, m_f = '1;
        logic [63:0] rnd;
        @(negedge clk);
        in_gameboard     = b;
        in_players_cells = o;
        start            = 1'b1;
        @(negedge clk);
        start            = 1'b0;
        rnd              = {$urandom(), $urandom()};
        in_gameboard     = rnd[41:0];
        rnd              = {$urandom(), $urandom()};
        in_players_cells = rnd[41:0];
        check({name, "_busy"}, 64'(busy_e), 64'(1));
        for (int n = 0; n < 80; n++) begin
            if (done_e) begin
                pul_e++;
                if (lat_e < 0) begin
                    lat_e = n; w_e = winner_e; d_e = draw_e; m_e = mask_e; bz_e = busy_e;
                end
            end
            if (done_f) begin
                pul_f++;
                if (lat_f < 0) begin
                    lat_f = n; w_f = winner_f; d_f = draw_f; m_f = mask_f;
                end
            end
            @(negedge clk);
        end
        check({name, "_lat_e"},    64'(lat_e), 64'(elat));
        check({name, "_pulses_e"}, 64'(pul_e), 64'(1));
        check({name, "_winner_e"}, 64'(w_e),   64'(ew));
        check({name, "_draw_e"},   64'(d_e),   64'(ed));
        check({name, "_mask_e"},   64'(m_e),   64'(em));
        check({name, "_busy_done"}, 64'(bz_e), 64'(0));
        check({name, "_lat_f"},    64'(lat_f), 64'(70));
        check({name, "_pulses_f"}, 64'(pul_f), 64'(1));
        check({name, "_winner_f"}, 64'(w_f),   64'(ew));
        check({name, "_draw_f"},   64'(d_f),   64'(ed));
        check({name, "_mask_f"},   64'(m_f),   64'(em));
    endtask

    initial begin
        logic [41:0] chk_owner;
        logic [41:0] col6;
        logic [41:0] rb, ro, mm;
        logic [1:0]  mw;
        logic        md;
        int          ml, dens, pul_e, pul_f, lat_e;

        reset            = 1'b0;
        start            = 1'b0;
        in_gameboard     = '0;
        in_players_cells = '0;
        build_windows();

        for (int r = 0; r < 6; r++)
            for (int c = 0; c < 7; c++)
                chk_owner[r * 7 + c] = 1'(((c >> 1) + r) & 1);
        col6 = bits4(6, 13, 20, 27);

        add_vec("p1_bottom",     42'hF, '0, 2'b01, 1'b0, 42'hF, 2);
        add_vec("p2_col6",       col6, col6, 2'b10, 1'b0, col6, 32);
        add_vec("p1_diag_ul",    bits4(3, 9, 15, 21), '0, 2'b01, 1'b0, bits4(3, 9, 15, 21), 59);
        add_vec("empty",         '0, '0, 2'b00, 1'b0, '0, 70);
        add_vec("full_no_win",   '1, chk_owner, 2'b00, 1'b1, '0, 70);
        add_vec("p2_top_right",  bits4(38, 39, 40, 41), bits4(38, 39, 40, 41), 2'b10, 1'b0,
                bits4(38, 39, 40, 41), 25);
        add_vec("p2_diag_ur",    bits4(0, 8, 16, 24), bits4(0, 8, 16, 24), 2'b10, 1'b0,
                bits4(0, 8, 16, 24), 47);
        add_vec("p1_last_win",   bits4(20, 26, 32, 38), '0, 2'b01, 1'b0, bits4(20, 26, 32, 38), 70);
        add_vec("mixed_owner",   42'hF, 42'h8, 2'b00, 1'b0, '0, 70);
        add_vec("empty_owner",   42'hF, ~42'hF, 2'b01, 1'b0, 42'hF, 2);
        add_vec("two_wins",      42'hF | col6, col6, 2'b01, 1'b0, 42'hF, 2);

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_busy_e",   64'(busy_e),   64'(0));
        check("rst_done_e",   64'(done_e),   64'(0));
        check("rst_winner_e", 64'(winner_e), 64'(0));
        check("rst_draw_e",   64'(draw_e),   64'(0));
        check("rst_mask_e",   64'(mask_e),   64'(0));
        check("rst_busy_f",   64'(busy_f),   64'(0));
        reset = 1'b1;

        foreach (vq[i])
            run_case(vq[i].name, vq[i].board, vq[i].owner, vq[i].winner,
                     vq[i].draw, vq[i].mask, vq[i].lat);

        // Results hold while idle.
        run_case("hold_setup", 42'hF, '0, 2'b01, 1'b0, 42'hF, 2);
        repeat (5) @(negedge clk);
        check("hold_winner_e", 64'(winner_e), 64'(2'b01));
        check("hold_mask_f",   64'(mask_f),   64'(42'hF));

        // Reset in idle clears held results.
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check("idle_rst_winner_e", 64'(winner_e), 64'(0));
        check("idle_rst_mask_f",   64'(mask_f),   64'(0));

        // Second start during a scan is ignored.
        @(negedge clk);
        in_gameboard = '0; in_players_cells = '0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        pul_e = 0; pul_f = 0; lat_e = -1;
        for (int n = 0; n < 90; n++) begin
            if (n == 5) begin
                in_gameboard = 42'hF;
                start        = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (done_e) begin
                pul_e++;
                if (lat_e < 0) lat_e = n;
            end
            if (done_f) pul_f++;
            @(negedge clk);
        end
        start = 1'b0;
        check("restart_pulses_e", 64'(pul_e),    64'(1));
        check("restart_pulses_f", 64'(pul_f),    64'(1));
        check("restart_lat_e",    64'(lat_e),    64'(70));
        check("restart_winner_e", 64'(winner_e), 64'(0));

        // Reset mid-scan aborts with no done.
        in_gameboard = 42'hF; in_players_cells = '0;
        run_case("pre_abort", 42'hF, '0, 2'b01, 1'b0, 42'hF, 2);
        @(negedge clk);
        in_gameboard = bits4(20, 26, 32, 38); in_players_cells = '0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check("abort_busy_e",   64'(busy_e),   64'(0));
        check("abort_busy_f",   64'(busy_f),   64'(0));
        check("abort_winner_e", 64'(winner_e), 64'(0));
        pul_e = 0;
        for (int n = 0; n < 80; n++) begin
            if (done_e || done_f) pul_e++;
            @(negedge clk);
        end
        check("abort_no_done", 64'(pul_e), 64'(0));

        // A fresh start after reset completes normally.
        run_case("after_abort", bits4(6, 13, 20, 27), bits4(6, 13, 20, 27), 2'b10, 1'b0,
                 bits4(6, 13, 20, 27), 32);

        // Random boards against the reference model.
        for (int t = 0; t < 40; t++) begin
            dens = $urandom_range(20, 100);
            for (int c = 0; c < 42; c++) begin
                rb[c] = ($urandom_range(0, 99) < dens);
                ro[c] = 1'($urandom_range(0, 1));
            end
            model(rb, ro, mw, md, mm, ml);
            run_case($sformatf("rand%0d", t), rb, ro, mw, md, mm, ml);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/win_detector.md
Name: win_detector

Overview:
- Downstream consumer of the column-selector stage's occupancy board (`out_gameboard`) and ownership board (`out_players_cells`).
- On a `start` pulse it snapshots both 42-bit boards and scans all 69 four-in-a-row windows, one window per clock.
- Reports the winner, a draw, and a 42-bit mask of the winning cells.
- The game FSM pulses `start` after every accepted move and waits for `done`.

Parameters:
- EARLY_EXIT, 1: 1 = stop at the first winning window; 0 = always scan all 69 windows and report the first winning window found.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-low reset
- start  input  1  one-cycle request to evaluate the current boards
- in_gameboard  input  42  cell occupancy; 1 = selected, 0 = empty
- in_players_cells  input  42  cell owner; 0 = player 1, 1 = player 2; valid only where occupied
- busy  output  1  high while a scan is in progress
- done  output  1  one-cycle pulse when the result is valid
- winner  output  2  2'b00 none, 2'b01 player 1, 2'b10 player 2
- draw  output  1  board full and no winner
- win_mask  output  42  cells of the winning window; 0 if no win

Behaviour:
- Cell index = row*7 + col; row 0 is the bottom row, col 0 is the leftmost column.
- Reset:
  - Sampled on the rising edge of clk while reset=0.
  - State goes to IDLE; busy=0, done=0, winner=0, draw=0, win_mask=0, window counter=0.
  - Reset mid-scan aborts the scan; no done pulse is produced.
- States: IDLE, SCAN, DONE.
- IDLE:
  - start=1 latches in_gameboard and in_players_cells into snapshot registers.
  - Clears winner, draw and win_mask, sets idx=0, moves to SCAN; busy=1 from the next cycle.
- SCAN:
  - Evaluates window idx from the snapshot each cycle.
  - A window wins when all 4 cells are occupied and all 4 owner bits are equal.
- Window order (7-bit idx, 0..68):
  - Horizontal, idx 0-23: idx = r*4 + c, cells (r, c+i).
  - Vertical, idx 24-44: idx = 24 + r*7 + c, r 0..2, cells (r+i, c).
  - Diagonal up-right, idx 45-56: idx = 45 + r*4 + c, cells (r+i, c+i).
  - Diagonal up-left, idx 57-68: idx = 57 + r*4 + c, cells (r+i, c+3-i), c 0..3.
- Win, EARLY_EXIT=1:
  - Register winner (owner bit 0 gives 01, owner bit 1 gives 10) and the 4-cell win_mask; go to DONE.
- Win, EARLY_EXIT=0:
  - Record only the first winning window and continue scanning.
- idx==68 with the scan complete: register draw = (&snapshot_gameboard) && no win recorded; go to DONE.
- DONE: done=1 for exactly one cycle, busy=0, return to IDLE.
- winner, draw and win_mask hold until the next accepted start or reset.
- Latency, start sampled at edge T:
  - With EARLY_EXIT=1 and a win at window k, done is high in the cycle after edge T+2+k.
  - With no win, done follows edge T+70.
- start while busy or in DONE is ignored; no queuing.
- The boards may change freely after start is accepted; only the snapshot is used.
- Ownership bits of empty cells are ignored.
- winner is never 2'b11. draw and winner!=0 are mutually exclusive.

Decomposition:
- Shared package connect4_pkg:
  - ROWS=6, COLS=7, CELLS=42, NUM_WINDOWS=69, window-range base constants (0, 24, 45, 57).
  - winner encoding constants; FSM state enum.
- One sub-module, win_window_lookup:
  - Combinational map from idx[6:0] to four 6-bit cell indices.
  - Also produces the 42-bit one-hot-of-4 window mask.
  - The checker FSM instantiates it once.

Test Plan:
- Player 1 bottom row, in_gameboard=42'hF, in_players_cells=0, start at T:
  - done after T+2 (window 0), winner=01, win_mask=42'hF, draw=0.
- Player 2 column 6, rows 0-3 (cells 6, 13, 20, 27 set in both boards):
  - window 30 wins; done after T+32, winner=10, win_mask has only bits 6, 13, 20, 27 set.
- Player 1 up-left diagonal, cells 3, 9, 15, 21 (window 57):
  - winner=01 after T+59.
- Empty board:
  - done after T+70, winner=00, draw=0, win_mask=0.
- Full board in a no-win checker pattern (owner = ((col>>1)+row)&1 style verified pattern):
  - done after T+70, draw=1, winner=00.
- Robustness:
  - Second start at T+5 is ignored: one done pulse only.
  - reset=0 at T+10 gives busy=0, no done, outputs 0.
  - A new start after reset completes normally.
